// File: rtl/host_stream_unpacker.sv
// host_stream_unpacker: splits 32-bit host FIFO words into a framed 16-bit request/response stream
module host_stream_unpacker #(
    parameter int          FRAME_WORDS = 64,
    parameter logic [15:0] IDLE_WORD   = 16'h0000
) (
    input  logic        dataclk,
    input  logic        fifo_reset,
    input  logic        enable,
    input  logic [31:0] fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rden,
    input  logic        word_req,
    output logic        word_valid,
    output logic [15:0] word_data,
    output logic        word_live,
    output logic        frame_start,
    output logic        underflow,
    output logic [15:0] frame_count
);
    localparam int PW = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, STREAM, HALT} state_t;
    state_t state, state_nx;
    logic [PW-1:0] pos;
    logic          half;
    logic [15:0]   hold;
    logic start, pop, from_hold, live, starve, last;
    // state register; only fifo_reset leaves HALT
    always_ff @(posedge dataclk or posedge fifo_reset) begin
        if (fifo_reset) state <= IDLE;
        else            state <= state_nx;
    end
    // frame start, starvation and end-of-frame decide the next state
    always_comb begin
        state_nx = start ? STREAM : starve ? HALT : last ? IDLE : state;
    end
    // per-request decode; pops only when the FIFO head is valid
    always_comb begin
        start     = state == IDLE && word_req && enable && !fifo_empty;
        pop       = start || (state == STREAM && word_req && !half && !fifo_empty);
        from_hold = state == STREAM && word_req && half;
        live      = pop || from_hold;
        starve    = state == STREAM && word_req && !half && fifo_empty;
        last      = state == STREAM && live && pos == PW'(FRAME_WORDS - 1);
        fifo_rden = pop;
    end
    // frame position and the buffered upper half of the last popped word
    always_ff @(posedge dataclk or posedge fifo_reset) begin
        if (fifo_reset) begin
            pos  <= '0;
            half <= 1'b0;
            hold <= '0;
        end else begin
            pos  <= last ? '0 : live ? pos + PW'(1) : pos;
            half <= pop ? 1'b1 : from_hold ? 1'b0 : half;
            hold <= pop ? fifo_dout[31:16] : hold;
        end
    end
    // registered response, one cycle after each request
    always_ff @(posedge dataclk or posedge fifo_reset) begin
        if (fifo_reset) begin
            word_valid  <= 1'b0;
            word_data   <= IDLE_WORD;
            word_live   <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            frame_count <= '0;
        end else begin
            word_valid  <= word_req;
            word_data   <= from_hold ? hold : pop ? fifo_dout[15:0] : IDLE_WORD;
            word_live   <= live;
            frame_start <= start;
            underflow   <= underflow | starve;
            frame_count <= frame_count + {15'd0, last};
        end
    end
endmodule

// File: tb/tb_host_stream_unpacker.sv
// tb_host_stream_unpacker: directed checks of the host stream unpacker against an FWFT FIFO model
module tb_host_stream_unpacker;
    localparam logic [15:0] IW = 16'hE1D0;
    logic        dataclk = 0, fifo_reset = 1, enable = 0, word_req = 0, flush = 0;
    logic [31:0] fifo_dout;
    logic        fifo_empty, fifo_rden, word_valid, word_live, frame_start, underflow;
    logic [15:0] word_data, frame_count;
    logic [31:0] mem [64];
    int rp = 0, wp = 0, pops = 0, bad_pops = 0, errors = 0, checks = 0;

    host_stream_unpacker #(.FRAME_WORDS(4), .IDLE_WORD(IW)) dut (
        .dataclk(dataclk), .fifo_reset(fifo_reset), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rden(fifo_rden),
        .word_req(word_req), .word_valid(word_valid), .word_data(word_data),
        .word_live(word_live), .frame_start(frame_start), .underflow(underflow),
        .frame_count(frame_count)
    );

    always #5 dataclk = ~dataclk;
    assign fifo_empty = (rp == wp);
    assign fifo_dout  = mem[rp[5:0]];

    // FWFT FIFO read side
    always @(posedge dataclk) begin
        if (fifo_rden && fifo_empty) bad_pops <= bad_pops + 1;
        if (flush) rp <= wp;
        else if (fifo_rden) begin
            rp   <= rp + 1;
            pops <= pops + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp[5:0]] = w;
        wp++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge dataclk);
            #1;
        end
    endtask

    // one request; response checked one cycle later
    task automatic req(input string tag, input logic [15:0] d, input logic lv, input logic fs, input logic rd);
        word_req = 1;
        #1;
        chk({tag, "_rden"}, fifo_rden, rd);
        @(posedge dataclk);
        #1;
        word_req = 0;
        chk({tag, "_valid"}, word_valid, 1);
        chk({tag, "_data"}, word_data, d);
        chk({tag, "_live"}, word_live, lv);
        chk({tag, "_fs"}, frame_start, fs);
    endtask

    initial begin
        int p0;
        tick(3);
        chk("rst_valid", word_valid, 0);
        chk("rst_data", word_data, IW);
        chk("rst_live", word_live, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_fc", frame_count, 0);
        fifo_reset = 0;
        tick(1);
        // 1: basic unpack order
        push(32'hBBBB_AAAA);
        push(32'hDDDD_CCCC);
        enable = 1;
        req("t1w0", 16'hAAAA, 1, 1, 1);
        req("t1w1", 16'hBBBB, 1, 0, 0);
        req("t1w2", 16'hCCCC, 1, 0, 1);
        req("t1w3", 16'hDDDD, 1, 0, 0);
        tick(1);
        chk("t1_novalid", word_valid, 0);
        chk("t1_pops", pops, 2);
        chk("t1_fc", frame_count, 1);
        // 2: three frames, spaced requests
        for (int i = 0; i < 6; i++) push({16'h0101 + 16'(2 * i), 16'h0100 + 16'(2 * i)});
        for (int j = 0; j < 12; j++) begin
            req($sformatf("t2w%0d", j), 16'h0100 + 16'(j), 1, (j % 4) == 0, (j % 2) == 0);
            tick(2);
            chk("t2_gap", word_valid, 0);
        end
        chk("t2_fc", frame_count, 4);
        chk("t2_pops", pops, 8);
        // 3: gap between frames with empty FIFO
        for (int j = 0; j < 5; j++) req($sformatf("t3w%0d", j), IW, 0, 0, 0);
        chk("t3_uf", underflow, 0);
        chk("t3_pops", pops, 8);
        // 4: mid-frame starvation
        push(32'hBBBB_AAAA);
        req("t4w0", 16'hAAAA, 1, 1, 1);
        req("t4w1", 16'hBBBB, 1, 0, 0);
        req("t4w2", IW, 0, 0, 0);
        chk("t4_uf_set", underflow, 1);
        req("t4w3", IW, 0, 0, 0);
        push(32'h2222_1111);
        push(32'h4444_3333);
        req("t4h0", IW, 0, 0, 0);
        req("t4h1", IW, 0, 0, 0);
        chk("t4_halt_pops", pops, 9);
        chk("t4_uf_sticky", underflow, 1);
        chk("t4_fc_pre", frame_count, 4);
        fifo_reset = 1;
        flush = 1;
        #1;
        chk("t4_rst_uf", underflow, 0);
        chk("t4_rst_fc", frame_count, 0);
        tick(1);
        fifo_reset = 0;
        flush = 0;
        tick(1);
        // 5: enable dropped mid-frame
        push(32'h0002_0001);
        push(32'h0004_0003);
        push(32'h0006_0005);
        push(32'h0008_0007);
        p0 = pops;
        req("t5w0", 16'h0001, 1, 1, 1);
        enable = 0;
        req("t5w1", 16'h0002, 1, 0, 0);
        req("t5w2", 16'h0003, 1, 0, 1);
        req("t5w3", 16'h0004, 1, 0, 0);
        req("t5w4", IW, 0, 0, 0);
        chk("t5_pops", pops - p0, 2);
        chk("t5_fc", frame_count, 1);
        // 6: back-to-back requests over two frames
        push(32'h000A_0009);
        push(32'h000C_000B);
        enable = 1;
        for (int j = 0; j < 8; j++)
            req($sformatf("t6w%0d", j), 16'h0005 + 16'(j), 1, (j % 4) == 0, (j % 2) == 0);
        tick(1);
        chk("t6_novalid", word_valid, 0);
        chk("t6_fc", frame_count, 3);
        chk("t6_pops", pops - p0, 6);
        chk("t6_uf", underflow, 0);
        chk("rden_empty", bad_pops, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
